// File: rtl/ex_pkg.sv
// Shared types for the ID/EX operand stage.
// ALU op codes, buffered entry layout and default widths.
package ex_pkg;

   localparam int XLEN_DEF = 32;
   localparam int RA_W_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_GE   = 4'd10,
      ALU_EQ   = 4'd11,
      ALU_NE   = 4'd12,
      ALU_GEU  = 4'd13
   } alu_op_e;

   typedef struct packed {
      alu_op_e               alu_ctrl;
      logic                  src_a_sel;
      logic                  src_b_sel;
      logic [RA_W_DEF-1:0]   rs1_addr;
      logic [RA_W_DEF-1:0]   rs2_addr;
      logic [RA_W_DEF-1:0]   rd_addr;
      logic [XLEN_DEF-1:0]   rs1_data;
      logic [XLEN_DEF-1:0]   rs2_data;
      logic [XLEN_DEF-1:0]   pc;
      logic [XLEN_DEF-1:0]   imm;
   } ex_entry_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Operand bypass for one source register.
// MEM beats WB; x0 always resolves to zero.
module ex_fwd_mux
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RA_W = RA_W_DEF
) (
   input  logic [RA_W-1:0] addr_i,
   input  logic [XLEN-1:0] rf_data_i,
   input  logic            mem_we_i,
   input  logic [RA_W-1:0] mem_rd_i,
   input  logic [XLEN-1:0] mem_data_i,
   input  logic            wb_we_i,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic [XLEN-1:0] data_o
);

   logic is_x0;
   logic mem_hit;
   logic wb_hit;

   assign is_x0   = (addr_i == '0);
   assign mem_hit = !is_x0 && mem_we_i && (mem_rd_i == addr_i);
   assign wb_hit  = !is_x0 && !mem_hit && wb_we_i &&
                    (wb_rd_i == addr_i);

   always_comb begin
      data_o = rf_data_i;
      unique case (1'b1)
         is_x0:   data_o = '0;
         mem_hit: data_o = mem_data_i;
         wb_hit:  data_o = wb_data_i;
         default: data_o = rf_data_i;
      endcase
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX boundary: 2-entry skid buffer with head-side forwarding
// and ALU operand selection.
module ex_operand_stage
   import ex_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int RA_W = RA_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_alu_ctrl,
   input  logic            in_src_a_sel,
   input  logic            in_src_b_sel,
   input  logic [RA_W-1:0] in_rs1_addr,
   input  logic [RA_W-1:0] in_rs2_addr,
   input  logic [RA_W-1:0] in_rd_addr,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic            fwd_mem_we,
   input  logic            fwd_wb_we,
   input  logic [RA_W-1:0] fwd_mem_rd,
   input  logic [RA_W-1:0] fwd_wb_rd,
   input  logic [XLEN-1:0] fwd_mem_data,
   input  logic [XLEN-1:0] fwd_wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_ctrl,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [XLEN-1:0] out_store_data,
   output logic [RA_W-1:0] out_rd_addr
);

   ex_entry_t head_q, head_d;
   ex_entry_t tail_q, tail_d;
   logic [1:0] count_q, count_d;
   ex_entry_t in_entry;
   logic push;
   logic pop;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      in_entry           = '0;
      in_entry.alu_ctrl  = alu_op_e'(in_alu_ctrl);
      in_entry.src_a_sel = in_src_a_sel;
      in_entry.src_b_sel = in_src_b_sel;
      in_entry.rs1_addr  = in_rs1_addr;
      in_entry.rs2_addr  = in_rs2_addr;
      in_entry.rd_addr   = in_rd_addr;
      in_entry.rs1_data  = in_rs1_data;
      in_entry.rs2_data  = in_rs2_data;
      in_entry.pc        = in_pc;
      in_entry.imm       = in_imm;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         unique case (count_q)
            2'd0: begin
               if (push) begin
                  head_d  = in_entry;
                  count_d = 2'd1;
               end
            end
            2'd1: begin
               // push+pop at count 1: the new entry replaces head
               if (push && pop) begin
                  head_d = in_entry;
               end else if (push) begin
                  tail_d  = in_entry;
                  count_d = 2'd2;
               end else if (pop) begin
                  count_d = 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head_d  = tail_q;
                  count_d = 2'd1;
               end
            end
            default: count_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
      .addr_i     (head_q.rs1_addr),
      .rf_data_i  (head_q.rs1_data),
      .mem_we_i   (fwd_mem_we),
      .mem_rd_i   (fwd_mem_rd),
      .mem_data_i (fwd_mem_data),
      .wb_we_i    (fwd_wb_we),
      .wb_rd_i    (fwd_wb_rd),
      .wb_data_i  (fwd_wb_data),
      .data_o     (rs1_val)
   );

   ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
      .addr_i     (head_q.rs2_addr),
      .rf_data_i  (head_q.rs2_data),
      .mem_we_i   (fwd_mem_we),
      .mem_rd_i   (fwd_mem_rd),
      .mem_data_i (fwd_mem_data),
      .wb_we_i    (fwd_wb_we),
      .wb_rd_i    (fwd_wb_rd),
      .wb_data_i  (fwd_wb_data),
      .data_o     (rs2_val)
   );

   always_comb begin
      out_alu_ctrl   = '0;
      out_a          = '0;
      out_b          = '0;
      out_store_data = '0;
      out_rd_addr    = '0;
      if (out_valid) begin
         out_alu_ctrl   = head_q.alu_ctrl;
         out_a          = head_q.src_a_sel ? head_q.pc : rs1_val;
         out_b          = head_q.src_b_sel ? head_q.imm : rs2_val;
         out_store_data = rs2_val;
         out_rd_addr    = head_q.rd_addr;
      end
   end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage with a queue-based
// reference model and randomized traffic.
module tb_ex_operand_stage;

   localparam int VW = 107;

   typedef struct {
      logic [3:0]  alu;
      logic        sa;
      logic        sb;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  rd;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] pc;
      logic [31:0] imm;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_alu_ctrl = '0;
   logic        in_src_a_sel = 1'b0;
   logic        in_src_b_sel = 1'b0;
   logic [4:0]  in_rs1_addr = '0;
   logic [4:0]  in_rs2_addr = '0;
   logic [4:0]  in_rd_addr = '0;
   logic [31:0] in_rs1_data = '0;
   logic [31:0] in_rs2_data = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_imm = '0;
   logic        fwd_mem_we = 1'b0;
   logic        fwd_wb_we = 1'b0;
   logic [4:0]  fwd_mem_rd = '0;
   logic [4:0]  fwd_wb_rd = '0;
   logic [31:0] fwd_mem_data = '0;
   logic [31:0] fwd_wb_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_alu_ctrl;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd_addr;

   int checks = 0;
   int errors = 0;
   ent_t q[$];

   always #5 clk = ~clk;

   ex_operand_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_ctrl(in_alu_ctrl),
      .in_src_a_sel(in_src_a_sel), .in_src_b_sel(in_src_b_sel),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rd_addr(in_rd_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_pc(in_pc), .in_imm(in_imm),
      .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
      .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
      .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_ctrl(out_alu_ctrl),
      .out_a(out_a), .out_b(out_b),
      .out_store_data(out_store_data),
      .out_rd_addr(out_rd_addr)
   );

   function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] d);
      if (r == 5'd0) return 32'd0;
      if (fwd_mem_we && fwd_mem_rd == r) return fwd_mem_data;
      if (fwd_wb_we && fwd_wb_rd == r) return fwd_wb_data;
      return d;
   endfunction

   function automatic logic [VW-1:0] exp_vec();
      ent_t e;
      logic rdy;
      logic [31:0] a, b, sd;
      rdy = (q.size() < 2);
      if (q.size() == 0) return {1'b0, rdy, 105'd0};
      e  = q[0];
      a  = e.sa ? e.pc : fwd(e.r1, e.d1);
      sd = fwd(e.r2, e.d2);
      b  = e.sb ? e.imm : sd;
      return {1'b1, rdy, e.alu, a, b, sd, e.rd};
   endfunction

   function automatic logic [VW-1:0] act_vec();
      return {out_valid, in_ready, out_alu_ctrl, out_a, out_b,
              out_store_data, out_rd_addr};
   endfunction

   function automatic ent_t cur_in();
      ent_t e;
      e.alu = in_alu_ctrl; e.sa = in_src_a_sel; e.sb = in_src_b_sel;
      e.r1 = in_rs1_addr; e.r2 = in_rs2_addr; e.rd = in_rd_addr;
      e.d1 = in_rs1_data; e.d2 = in_rs2_data;
      e.pc = in_pc; e.imm = in_imm;
      return e;
   endfunction

   // Advance model and DUT by one edge; returns at the next negedge.
   task automatic tick();
      bit acc, pop, fl;
      ent_t e;
      fl  = flush;
      acc = in_valid && (q.size() < 2);
      pop = (q.size() != 0) && out_ready;
      e   = cur_in();
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic set_in(logic [3:0] alu, logic sa, logic sb,
                         logic [4:0] r1, logic [31:0] d1,
                         logic [4:0] r2, logic [31:0] d2,
                         logic [4:0] rd, logic [31:0] pc,
                         logic [31:0] imm);
      in_alu_ctrl = alu; in_src_a_sel = sa; in_src_b_sel = sb;
      in_rs1_addr = r1; in_rs1_data = d1;
      in_rs2_addr = r2; in_rs2_data = d2;
      in_rd_addr = rd; in_pc = pc; in_imm = imm;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      checks++;
      if (act_vec() !== {1'b0, 1'b1, 105'd0}) begin
         errors++;
         $display("FAIL reset: got %h want %h", act_vec(),
                  {1'b0, 1'b1, 105'd0});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_in(4'd0, 0, 0, 5'd5, 32'd3, 5'd6, 32'd4, 5'd1, 0, 0);
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_alu_ctrl, out_a, out_b} !==
          {1'b1, 4'd0, 32'd3, 32'd4}) begin
         errors++;
         $display("FAIL basic_add: got v=%b op=%0d a=%h b=%h want 1 0 3 4",
                  out_valid, out_alu_ctrl, out_a, out_b);
      end
      out_ready = 1'b1;
      tick();
      #1;
      checks++;
      if (act_vec() !== exp_vec() || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_pop: got %h want %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] rd_seq[3] = '{5'd10, 5'd11, 5'd12};
      logic       rdy_exp[3] = '{1'b1, 1'b1, 1'b0};
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_in(4'(i + 1), 0, 0, 5'd1, 32'(i), 5'd2, 32'(i), rd_seq[i], 0, 0);
         #1;
         checks++;
         if (in_ready !== rdy_exp[i]) begin
            errors++;
            $display("FAIL b2b_ready%0d: got %b want %b", i, in_ready,
                     rdy_exp[i]);
         end
         tick();
      end
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_rd_addr !== 5'd10) begin
         errors++;
         $display("FAIL b2b_full: got rdy=%b rd=%0d want 0 10",
                  in_ready, out_rd_addr);
      end
      out_ready = 1'b1;
      for (int i = 1; i < 3; i++) begin
         tick();
         if (i == 2) in_valid = 1'b0;
         #1;
         checks++;
         if (out_rd_addr !== rd_seq[i] || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL b2b_order%0d: got rd=%0d want %0d", i,
                     out_rd_addr, rd_seq[i]);
         end
      end
      tick();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: got v=%b want 0", out_valid);
      end
   endtask

   task automatic test_fwd_priority();
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_in(4'd0, 0, 0, 5'd7, 32'h11, 5'd3, 32'h22, 5'd4, 0, 0);
      tick();
      in_valid = 1'b0;
      fwd_mem_we = 1'b1; fwd_mem_rd = 5'd7; fwd_mem_data = 32'hAA;
      fwd_wb_we = 1'b1; fwd_wb_rd = 5'd7; fwd_wb_data = 32'hBB;
      #1;
      checks++;
      if (out_a !== 32'hAA) begin
         errors++;
         $display("FAIL fwd_mem_prio: got %h want %h", out_a, 32'hAA);
      end
      fwd_mem_we = 1'b0;
      #1;
      checks++;
      if (out_a !== 32'hBB) begin
         errors++;
         $display("FAIL fwd_wb: got %h want %h", out_a, 32'hBB);
      end
      fwd_wb_we = 1'b0;
      #1;
      checks++;
      if (out_a !== 32'h11) begin
         errors++;
         $display("FAIL fwd_none: got %h want %h", out_a, 32'h11);
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_x0();
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_in(4'd1, 0, 0, 5'd0, 32'h77, 5'd0, 32'h55, 5'd2, 0, 0);
      tick();
      in_valid = 1'b0;
      fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_mem_data = 32'h99;
      #1;
      checks++;
      if ({out_a, out_b, out_store_data} !== 96'd0) begin
         errors++;
         $display("FAIL x0: got a=%h b=%h sd=%h want 0 0 0",
                  out_a, out_b, out_store_data);
      end
      fwd_mem_we = 1'b0;
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_sel();
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_in(4'd0, 1, 1, 5'd3, 32'h1, 5'd4, 32'h2, 5'd5,
             32'h100, 32'hFFFF_FFFC);
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if ({out_a, out_b, out_store_data} !==
          {32'h100, 32'hFFFF_FFFC, 32'h2}) begin
         errors++;
         $display("FAIL sel: got a=%h b=%h sd=%h want 100 fffffffc 2",
                  out_a, out_b, out_store_data);
      end
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_flush_reset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      set_in(4'd5, 0, 0, 5'd1, 32'h5, 5'd2, 32'h6, 5'd9, 0, 0);
      tick();
      tick();
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_full: got rdy=%b v=%b want 0 1",
                  in_ready, out_valid);
      end
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (act_vec() !== {1'b0, 1'b1, 105'd0}) begin
         errors++;
         $display("FAIL flush: got %h want %h", act_vec(),
                  {1'b0, 1'b1, 105'd0});
      end
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (act_vec() !== {1'b0, 1'b1, 105'd0}) begin
         errors++;
         $display("FAIL async_reset: got %h want %h", act_vec(),
                  {1'b0, 1'b1, 105'd0});
      end
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 15) == 0);
         set_in(4'($urandom_range(0, 13)), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), $urandom,
                5'($urandom), $urandom, $urandom);
         fwd_mem_we = 1'($urandom); fwd_mem_rd = 5'($urandom_range(0, 7));
         fwd_mem_data = $urandom;
         fwd_wb_we = 1'($urandom); fwd_wb_rd = 5'($urandom_range(0, 7));
         fwd_wb_data = $urandom;
         #1;
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random%0d: got %h want %h", i, act_vec(),
                     exp_vec());
         end
         tick();
      end
      flush = 1'b0;
      in_valid = 1'b0;
      fwd_mem_we = 1'b0;
      fwd_wb_we = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_fwd_priority();
      test_x0();
      test_sel();
      test_flush_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX boundary stage of the RV32I core. It captures decoded instructions from the decode stage into a 2-entry skid buffer with a valid/ready handshake. At the head entry it resolves operand forwarding from the MEM and WB stages and selects PC/immediate sources. It drives the ALU's ALUControl, a and b inputs plus the store-data and destination fields carried to EX/MEM.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width

Ports:
- clk  in  1  clock, all state rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all buffered and incoming instructions
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept; depends only on internal state
- in_alu_ctrl  in  4  ALU operation code (ex_pkg::alu_op_e)
- in_src_a_sel  in  1  0: rs1, 1: pc
- in_src_b_sel  in  1  0: rs2, 1: imm
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  RA_W  register addresses
- in_rs1_data, in_rs2_data, in_pc, in_imm  in  XLEN  register-file reads, PC, immediate
- fwd_mem_we, fwd_wb_we  in  1  MEM/WB will write a register
- fwd_mem_rd, fwd_wb_rd  in  RA_W  MEM/WB destination
- fwd_mem_data, fwd_wb_data  in  XLEN  MEM/WB result
- out_valid  out  1  head entry valid
- out_ready  in  1  EX/MEM accepts head
- out_alu_ctrl  out  4  to ALU ALUControl
- out_a, out_b  out  XLEN  to ALU a, b
- out_store_data  out  XLEN  forwarded rs2 value
- out_rd_addr  out  RA_W  destination

## Operation
- Storage: 2 entries (head, tail), occupancy count 0..2.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = (count < 2). out_valid = (count != 0).
- count 1, push and pop in the same cycle: count stays 1; the new entry becomes head.
- count 2, pop: tail moves to head, count becomes 1. No push is possible that cycle.
- Forwarding is evaluated combinationally at the head every cycle using live fwd buses, so a held entry picks up results that arrive while it stalls.
  - Per source register r: if fwd_mem_we && fwd_mem_rd == r && r != 0, use fwd_mem_data.
  - Else if fwd_wb_we && fwd_wb_rd == r && r != 0, use fwd_wb_data.
  - Else use the captured register data. MEM has priority over WB.
  - x0 always reads 0, regardless of captured data or forwarding.
- Operand selection:
  - out_a = src_a_sel ? pc : fwd(rs1).
  - out_b = src_b_sel ? imm : fwd(rs2).
  - out_store_data = fwd(rs2) always.
- When out_valid = 0, out_alu_ctrl, out_a, out_b, out_store_data and out_rd_addr are forced to 0.
- flush: count becomes 0 at the next edge. A push in the flush cycle is discarded. flush overrides push and pop.

## Timing
- Reset (asynchronous assert, synchronous deassert externally handled): count = 0, entries zeroed, out_valid = 0, in_ready = 1, all data outputs 0.
- Latency: an instruction accepted at edge N is presented at the outputs after edge N with out_valid = 1.
- Throughput: 1 instruction per cycle with out_ready held at 1.
- Stall: with out_ready = 0, the head fields are stable; only forwarded values may change.
- in_ready has no combinational path from out_ready. Outputs have a combinational path only from the fwd_* inputs.

## Structure
- ex_pkg holds:
  - alu_op_e (4-bit): ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, GE 10, EQ 11, NE 12, GEU 13.
  - ex_entry_t struct with fields alu_ctrl, src sels, rs1/rs2/rd addrs, rs1/rs2 data, pc, imm.
  - XLEN_DEF and RA_W_DEF constants.
- Sub-module ex_fwd_mux: one register address plus captured data plus both fwd ports in, resolved value out. Instantiated twice (rs1, rs2).

## Test plan
- Reset, then push ADD with rs1 = 5, data 3 and rs2 = 6, data 4 -> next cycle out_valid = 1, out_alu_ctrl = 0, out_a = 3, out_b = 4.
- Hold out_ready = 0 and push 3 instructions back-to-back -> in_ready drops after the 2nd push. The 3rd is not accepted until a pop. Output order is preserved.
- Head rs1 = 7. fwd_mem_we = 1, rd = 7, data 0xAA and fwd_wb_we = 1, rd = 7, data 0xBB -> out_a = 0xAA. Deassert fwd_mem_we -> out_a = 0xBB.
- Head rs2 = 0 with captured data 0x55, fwd_mem_we = 1, rd = 0, data 0x99 -> out_b = 0, out_store_data = 0.
- src_a_sel = 1, pc = 0x100; src_b_sel = 1, imm = 0xFFFFFFFC -> out_a = 0x100, out_b = 0xFFFFFFFC.
- count = 2, assert flush together with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, outputs 0. Then assert rst_n = 0 mid-stream -> outputs 0 immediately without waiting for a clock edge.
